// File: rtl/test_uart_tx_top.sv
// Self-running UART (8N1, LSB first) transmitter that repeats "TEST\r\n" forever.
// Exports a baud-rate clock and a mirror of tx for board bring-up probing.
module test_uart_tx_top #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD      = 115_200,
   parameter int unsigned IDLE_BITS = 2,
   parameter int unsigned GAP_BITS  = 10
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic tx,
   output logic bit_ck,
   output logic debug_tx
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned MSG_LEN      = 6;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
   localparam logic [2:0]       IDX_LAST = 3'(MSG_LEN - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] baud_nxt;
   logic             boundary;
   logic [1:0]       state;
   logic [15:0]      idle_cnt;
   logic [2:0]       byte_idx;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nxt;
   logic [7:0]       cur_byte;
   logic             tx_r;

   function automatic logic [7:0] msg_byte(input logic [2:0] i);
      case (i)
         3'd0:    msg_byte = 8'h54;
         3'd1:    msg_byte = 8'h45;
         3'd2:    msg_byte = 8'h53;
         3'd3:    msg_byte = 8'h54;
         3'd4:    msg_byte = 8'h0D;
         3'd5:    msg_byte = 8'h0A;
         default: msg_byte = 8'hFF;
      endcase
   endfunction

   always_comb begin
      boundary    = (baud_cnt == CNT_LAST);
      baud_nxt    = boundary ? '0 : baud_cnt + 1'b1;
      cur_byte    = msg_byte(byte_idx);
      bit_idx_nxt = bit_idx + 3'd1;
   end

   // tx is only ever updated on the edge where the baud counter reloads 0,
   // which is also the edge where bit_ck rises.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         baud_cnt <= '0;
         bit_ck   <= 1'b0;
         state    <= ST_IDLE;
         idle_cnt <= 16'(IDLE_BITS);
         byte_idx <= '0;
         bit_idx  <= '0;
         tx_r     <= 1'b1;
      end else begin
         baud_cnt <= baud_nxt;
         bit_ck   <= (baud_nxt < CNT_HALF);
         if (boundary) begin
            case (state)
               ST_IDLE: begin
                  if (idle_cnt == '0) begin
                     state    <= ST_START;
                     byte_idx <= '0;
                     tx_r     <= 1'b0;
                  end else begin
                     idle_cnt <= idle_cnt - 16'd1;
                     tx_r     <= 1'b1;
                  end
               end
               ST_START: begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
                  tx_r    <= cur_byte[0];
               end
               ST_DATA: begin
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx_r  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx_nxt;
                     tx_r    <= cur_byte[bit_idx_nxt];
                  end
               end
               default: begin
                  if (byte_idx != IDX_LAST) begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= ST_START;
                     tx_r     <= 1'b0;
                  end else begin
                     idle_cnt <= 16'(GAP_BITS);
                     state    <= ST_IDLE;
                     tx_r     <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign tx       = tx_r;
   assign debug_tx = tx_r;

endmodule

// File: tb/tb_test_uart_tx_top.sv
// Directed bench: one fast instance (100 clocks/bit) for frame decoding and one
// default instance (868 clocks/bit) for baud timing.
module tb_test_uart_tx_top;

   localparam int NCAP = 10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic f_tx, f_ck, f_dbg;
   logic d_tx, d_ck, d_dbg;

   logic f_tx_log [0:NCAP];
   logic f_ck_log [0:NCAP];
   logic d_tx_log [0:NCAP];
   logic d_ck_log [0:NCAP];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   test_uart_tx_top #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .IDLE_BITS(2), .GAP_BITS(10)) u_fast (
      .sys_clk(clk), .sys_rst(rst), .tx(f_tx), .bit_ck(f_ck), .debug_tx(f_dbg)
   );

   test_uart_tx_top u_def (
      .sys_clk(clk), .sys_rst(rst), .tx(d_tx), .bit_ck(d_ck), .debug_tx(d_dbg)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (f_tx !== 1'b1 || f_dbg !== 1'b1 || f_ck !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fast: tx=%b debug_tx=%b bit_ck=%b, required 1 1 0", f_tx, f_dbg, f_ck);
         end
         n_checks++;
         if (d_tx !== 1'b1 || d_dbg !== 1'b1 || d_ck !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_default: tx=%b debug_tx=%b bit_ck=%b, required 1 1 0", d_tx, d_dbg, d_ck);
         end
      end
   endtask

   task automatic test_startup();
      int f_fall, d_fall, r1, r2, fl;
      rst = 1'b0;
      f_tx_log[0] = f_tx; f_ck_log[0] = f_ck;
      d_tx_log[0] = d_tx; d_ck_log[0] = d_ck;
      for (int k = 1; k <= NCAP; k++) begin
         @(posedge clk); #1;
         f_tx_log[k] = f_tx; f_ck_log[k] = f_ck;
         d_tx_log[k] = d_tx; d_ck_log[k] = d_ck;
         n_checks++;
         if (f_dbg !== f_tx || d_dbg !== d_tx) begin
            n_fail++;
            $display("FAIL debug_mirror: cycle %0d fast %b/%b default %b/%b", k, f_dbg, f_tx, d_dbg, d_tx);
         end
      end
      f_fall = -1; d_fall = -1;
      for (int k = 1; k <= NCAP; k++) begin
         if (f_fall < 0 && f_tx_log[k] === 1'b0) f_fall = k;
         if (d_fall < 0 && d_tx_log[k] === 1'b0) d_fall = k;
      end
      n_checks++;
      if (f_fall != 300) begin
         n_fail++;
         $display("FAIL first_start_fast: tx fell at cycle %0d, required 300", f_fall);
      end
      n_checks++;
      if (d_fall != 2604) begin
         n_fail++;
         $display("FAIL first_start_default: tx fell at cycle %0d, required 2604", d_fall);
      end
      n_checks++;
      if (f_fall < 1 || f_ck_log[f_fall] !== 1'b1 || f_ck_log[f_fall-1] !== 1'b0) begin
         n_fail++;
         $display("FAIL start_on_bit_ck_rise_fast: tx fall not on a bit_ck rise (cycle %0d)", f_fall);
      end
      n_checks++;
      if (d_fall < 1 || d_ck_log[d_fall] !== 1'b1 || d_ck_log[d_fall-1] !== 1'b0) begin
         n_fail++;
         $display("FAIL start_on_bit_ck_rise_default: tx fall not on a bit_ck rise (cycle %0d)", d_fall);
      end
      // default bit_ck: rises at 868, 1736; falls at 1302
      r1 = -1; r2 = -1; fl = -1;
      for (int k = 2; k <= NCAP; k++) begin
         if (d_ck_log[k] === 1'b1 && d_ck_log[k-1] === 1'b0) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) r2 = k;
         end
         if (r1 > 0 && fl < 0 && d_ck_log[k] === 1'b0 && d_ck_log[k-1] === 1'b1) fl = k;
      end
      n_checks++;
      if (r1 != 868 || r2 - r1 != 868) begin
         n_fail++;
         $display("FAIL bit_ck_period_default: rises at %0d,%0d, required 868,1736", r1, r2);
      end
      n_checks++;
      if (fl - r1 != 434) begin
         n_fail++;
         $display("FAIL bit_ck_high_default: high %0d cycles, required 434", fl - r1);
      end
      r1 = -1; r2 = -1; fl = -1;
      for (int k = 2; k <= NCAP; k++) begin
         if (f_ck_log[k] === 1'b1 && f_ck_log[k-1] === 1'b0) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) r2 = k;
         end
         if (r1 > 0 && fl < 0 && f_ck_log[k] === 1'b0 && f_ck_log[k-1] === 1'b1) fl = k;
      end
      n_checks++;
      if (r1 != 100 || r2 != 200 || fl != 150) begin
         n_fail++;
         $display("FAIL bit_ck_fast: rise %0d rise %0d fall %0d, required 100 200 150", r1, r2, fl);
      end
   endtask

   task automatic test_first_frame();
      logic [9:0] exp_bits;
      exp_bits = 10'b1_0101_0100_0; // stop, 0x54 MSB..LSB, start
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (f_tx_log[300 + 100*i] !== exp_bits[i] || f_tx_log[300 + 100*i + 50] !== exp_bits[i] ||
             f_tx_log[300 + 100*i + 99] !== exp_bits[i]) begin
            n_fail++;
            $display("FAIL first_frame_bit%0d: samples %b%b%b, required %b over 100 cycles", i,
                     f_tx_log[300 + 100*i], f_tx_log[300 + 100*i + 50], f_tx_log[300 + 100*i + 99], exp_bits[i]);
         end
      end
   endtask

   task automatic test_message();
      logic [7:0] exp_bytes [8];
      logic [7:0] got;
      int pos, s, prev;
      bit idle_ok;
      exp_bytes = '{8'h54, 8'h45, 8'h53, 8'h54, 8'h0D, 8'h0A, 8'h54, 8'h45};
      pos = 1; prev = 0;
      for (int j = 0; j < 8; j++) begin
         s = -1;
         for (int k = pos; k <= NCAP - 1000; k++) begin
            if (s < 0 && f_tx_log[k] === 1'b0 && f_tx_log[k-1] === 1'b1) s = k;
         end
         n_checks++;
         if (s < 0) begin
            n_fail++;
            $display("FAIL frame%0d_found: no start bit seen, required one", j);
            return;
         end
         for (int i = 0; i < 8; i++) got[i] = f_tx_log[s + 150 + 100*i];
         n_checks++;
         if (got !== exp_bytes[j] || f_tx_log[s + 950] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame%0d_data: byte %h stop %b, required %h stop 1", j, got, f_tx_log[s + 950], exp_bytes[j]);
         end
         if (j > 0 && j != 6) begin
            n_checks++;
            if (s != prev + 1000) begin
               n_fail++;
               $display("FAIL frame%0d_back_to_back: start at %0d, required %0d", j, s, prev + 1000);
            end
         end
         if (j == 6) begin
            idle_ok = 1'b1;
            for (int k = prev + 1000; k < s; k++) if (f_tx_log[k] !== 1'b1) idle_ok = 1'b0;
            n_checks++;
            if (s - (prev + 1000) < 1000 || !idle_ok) begin
               n_fail++;
               $display("FAIL repeat_gap: idle %0d cycles high=%b, required >=1000 high=1", s - (prev + 1000), idle_ok);
            end
         end
         prev = s;
         pos = s + 1000;
      end
   endtask

   task automatic test_reset_mid_frame();
      int fall;
      logic prev_ck;
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2650) begin @(posedge clk); #1; end
      n_checks++;
      if (f_tx !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_frame_setup: tx=%b in data bit 2 of 0x53, required 0", f_tx);
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (f_tx !== 1'b1 || f_dbg !== 1'b1 || f_ck !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_frame_abort: tx=%b debug_tx=%b bit_ck=%b, required 1 1 0", f_tx, f_dbg, f_ck);
      end
      @(negedge clk) rst = 1'b0;
      fall = -1; prev_ck = f_ck;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (fall < 0 && f_tx === 1'b0) begin
            fall = k;
            n_checks++;
            if (f_ck !== 1'b1 || prev_ck !== 1'b0) begin
               n_fail++;
               $display("FAIL restart_bit_ck_align: bit_ck %b->%b at tx fall, required 0->1", prev_ck, f_ck);
            end
         end
         prev_ck = f_ck;
      end
      n_checks++;
      if (fall != 300) begin
         n_fail++;
         $display("FAIL restart_timing: tx fell at cycle %0d, required 300", fall);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_first_frame();
      test_message();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
